// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_master_bridge_if : cmd/rsp request port plus APB3 initiator bus   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface apb_master_bridge_if #(
  parameter int ADDR_W = 12,
  parameter int IDX_W  = 2,
  parameter int SLAVES = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_W-1:0]       cmd_addr;
  logic [31:0]             cmd_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [31:0]             rsp_rdata;
  logic                    rsp_error;
  logic [ADDR_W-IDX_W-1:0] m_PADDR;
  logic [SLAVES-1:0]       m_PSEL;
  logic                    m_PENABLE;
  logic                    m_PWRITE;
  logic [31:0]             m_PWDATA;
  logic                    m_PREADY;
  logic [31:0]             m_PRDATA;
  logic                    m_PSLVERROR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  m_PREADY, m_PRDATA, m_PSLVERROR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    output m_PADDR, m_PSEL, m_PENABLE, m_PWRITE, m_PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output m_PREADY, m_PRDATA, m_PSLVERROR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    input  m_PADDR, m_PSEL, m_PENABLE, m_PWRITE, m_PWDATA
  );
endinterface
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_master_bridge : single-outstanding cmd/rsp to APB3 initiator with |
// | one-hot slave decode. Optional ACCESS timeout: APB_TIMEOUT_EN.        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module apb_master_bridge #(
  parameter int ADDR_W         = 12,
  parameter int SLAVES         = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic            io_ahb_PCLK,
  input  wire logic            io_ahb_PRESET,
  apb_master_bridge_if.master  bus
);

  localparam int              c_LOC_W  = ADDR_W - IDX_W;
  localparam logic [IDX_W:0]  c_SLAVES = (IDX_W+1)'(SLAVES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              error_q, error_d;

  logic [IDX_W-1:0]  w_cmd_idx;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_decode_ok;
  logic              w_expire;

  assign w_cmd_idx   = bus.cmd_addr[ADDR_W-1 -: IDX_W];
  assign w_sel_idx   = addr_q[ADDR_W-1 -: IDX_W];
  assign w_decode_ok = {1'b0, w_cmd_idx} < c_SLAVES;

`ifdef APB_TIMEOUT_EN
  localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);

  logic [c_CNT_W-1:0] tcnt_q, tcnt_d;

  // Expiry is judged on the stall cycle that would bring the count to the limit.
  assign w_expire = (state_q == S_ACCESS) && !bus.m_PREADY &&
                    ((tcnt_q + c_CNT_W'(1)) == c_TIMEOUT);

  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == S_SETUP)
      tcnt_d = '0;
    else if (state_q == S_ACCESS && !bus.m_PREADY)
      tcnt_d = tcnt_q + c_CNT_W'(1);
  end

  always_ff @(posedge io_ahb_PCLK or posedge io_ahb_PRESET) begin
    if (io_ahb_PRESET) tcnt_q <= '0;
    else               tcnt_q <= tcnt_d;
  end
`else
  // Timeout compiled out: the parameter stays for a uniform instantiation interface.
  assign w_expire = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          write_d = bus.cmd_write;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          if (w_decode_ok) begin
            state_d = S_SETUP;
          end else begin
            state_d = S_RESP;
            error_d = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (bus.m_PREADY) begin
          rdata_d = write_q ? 32'd0 : bus.m_PRDATA;
          error_d = bus.m_PSLVERROR;
          state_d = S_RESP;
        end else if (w_expire) begin
          rdata_d = '0;
          error_d = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge io_ahb_PCLK or posedge io_ahb_PRESET) begin
    if (io_ahb_PRESET) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Select/enable decode straight from state so an async reset drops them at once.
  genvar i;
  generate
    for (i = 0; i < SLAVES; i++) begin : g_psel
      assign bus.m_PSEL[i] = ((state_q == S_SETUP) || (state_q == S_ACCESS)) &&
                             (w_sel_idx == IDX_W'(i));
    end
  endgenerate

  assign bus.m_PENABLE = (state_q == S_ACCESS);
  assign bus.m_PADDR   = addr_q[c_LOC_W-1:0];
  assign bus.m_PWRITE  = write_q;
  assign bus.m_PWDATA  = wdata_q;
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_apb_master_bridge : randomized and directed bench for the bridge   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_apb_master_bridge;

  localparam int ADDR_W = 12;
  localparam int IDX_W  = 2;
  localparam int SLAVES = 3;
  localparam int TO     = 8;
  localparam int LOC_W  = ADDR_W - IDX_W;
`ifdef APB_TIMEOUT_EN
  localparam bit TIMED = 1'b1;
`else
  localparam bit TIMED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  apb_master_bridge_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .SLAVES(SLAVES)) bus ();

  apb_master_bridge #(
    .ADDR_W(ADDR_W), .SLAVES(SLAVES), .IDX_W(IDX_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .io_ahb_PCLK   (clk),
    .io_ahb_PRESET (rst),
    .bus           (bus)
  );

  // observations from the last transaction
  int               o_lat, o_acc;
  logic [SLAVES-1:0] o_psel;
  logic [LOC_W-1:0] o_paddr;
  logic             o_pwrite, o_unstable, o_busy_ready, o_idle_ready;
  logic [31:0]      o_pwdata, o_rdata;
  logic             o_err, o_hold_bad, o_after_valid, o_after_ready;

  // expectations from the reference model
  int               e_lat, e_acc;
  logic [SLAVES-1:0] e_psel;
  logic [LOC_W-1:0] e_paddr;
  logic             e_err;
  logic [31:0]      e_rdata;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: decode, latency and response from the bus rules.
  task automatic model(input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] rd, input logic slverr, input int waits);
    int idx;
    idx     = int'(addr) / (1 << LOC_W);
    e_paddr = LOC_W'(int'(addr) % (1 << LOC_W));
    if (idx >= SLAVES) begin
      e_psel = '0; e_acc = 0; e_lat = 1; e_err = 1'b1; e_rdata = 32'd0;
    end else begin
      e_psel = SLAVES'(1 << idx);
      if (TIMED && waits >= TO) begin
        e_acc = TO; e_lat = 2 + TO; e_err = 1'b1; e_rdata = 32'd0;
      end else begin
        e_acc = waits + 1; e_lat = 3 + waits; e_err = slverr; e_rdata = wr ? 32'd0 : rd;
      end
    end
  endtask

  // Drives one request, plays the slave with `waits` stall cycles, holds rsp_ready low `delay` cycles.
  task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                         input int waits, input logic [31:0] rd, input logic slverr, input int delay);
    o_idle_ready  = bus.cmd_ready;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wd;
    tick();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'($urandom); bus.cmd_addr = ADDR_W'($urandom); bus.cmd_wdata = $urandom;
    o_lat = 0; o_acc = 0; o_psel = '0; o_paddr = '0; o_pwrite = 1'b0; o_pwdata = '0;
    o_unstable = 1'b0; o_busy_ready = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (bus.rsp_valid) begin o_lat = c; break; end
      if (bus.cmd_ready) o_busy_ready = 1'b1;
      if (bus.m_PENABLE) begin
        o_acc++;
        if (bus.m_PSEL !== o_psel || bus.m_PADDR !== o_paddr || bus.m_PWRITE !== o_pwrite ||
            bus.m_PWDATA !== o_pwdata) o_unstable = 1'b1;
        bus.m_PREADY    = (o_acc == waits + 1);
        bus.m_PRDATA    = (o_acc == waits + 1) ? rd : $urandom;
        bus.m_PSLVERROR = (o_acc == waits + 1) ? slverr : 1'($urandom);
      end else begin
        if (bus.m_PSEL != '0) begin
          o_psel = bus.m_PSEL; o_paddr = bus.m_PADDR; o_pwrite = bus.m_PWRITE; o_pwdata = bus.m_PWDATA;
        end
        bus.m_PREADY = 1'($urandom); bus.m_PRDATA = $urandom; bus.m_PSLVERROR = 1'($urandom);
      end
      tick();
    end
    o_err = bus.rsp_error; o_rdata = bus.rsp_rdata;
    o_hold_bad = (bus.m_PSEL != '0) || bus.m_PENABLE || bus.cmd_ready;
    for (int d = 0; d < delay; d++) begin
      bus.rsp_ready = 1'b0; bus.m_PREADY = 1'($urandom); bus.m_PRDATA = $urandom;
      tick();
      if (!bus.rsp_valid || bus.rsp_error !== o_err || bus.rsp_rdata !== o_rdata ||
          bus.cmd_ready || bus.m_PSEL != '0) o_hold_bad = 1'b1;
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0; bus.m_PREADY = 1'b0;
    o_after_valid = bus.rsp_valid; o_after_ready = bus.cmd_ready;
  endtask

  task automatic test_reset;
    n_vec++; if (bus.m_PSEL !== '0 || bus.m_PENABLE !== 1'b0) begin n_err++; $display("FAIL reset_sel: psel=%b pen=%b want 0/0", bus.m_PSEL, bus.m_PENABLE); end
    n_vec++; if (bus.m_PADDR !== '0 || bus.m_PWRITE !== 1'b0 || bus.m_PWDATA !== '0) begin n_err++; $display("FAIL reset_bus: paddr=%h pwrite=%b pwdata=%h want 0", bus.m_PADDR, bus.m_PWRITE, bus.m_PWDATA); end
    n_vec++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0 || bus.rsp_error !== 1'b0) begin n_err++; $display("FAIL reset_rsp: v=%b d=%h e=%b want 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_error); end
    n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_write;
    model(1'b1, 12'h004, 32'h0, 1'b0, 0);
    run_txn(1'b1, 12'h004, 32'h0000_0005, 0, 32'h0, 1'b0, 0);
    n_vec++; if (o_lat !== 3 || o_lat !== e_lat) begin n_err++; $display("FAIL wr_lat: got %0d want %0d", o_lat, e_lat); end
    n_vec++; if (o_psel !== 3'b001 || o_acc !== e_acc) begin n_err++; $display("FAIL wr_sel: psel=%b acc=%0d want 001/%0d", o_psel, o_acc, e_acc); end
    n_vec++; if (o_paddr !== e_paddr || o_pwrite !== 1'b1 || o_pwdata !== 32'h5) begin n_err++; $display("FAIL wr_bus: paddr=%h pwrite=%b pwdata=%h want %h/1/5", o_paddr, o_pwrite, o_pwdata, e_paddr); end
    n_vec++; if (o_err !== e_err || o_rdata !== e_rdata || o_unstable) begin n_err++; $display("FAIL wr_rsp: err=%b rdata=%h unstable=%b want %b/%h/0", o_err, o_rdata, o_unstable, e_err, e_rdata); end
  endtask

  task automatic test_read_wait;
    model(1'b0, 12'h818, 32'hDEAD_BEEF, 1'b0, 3);
    run_txn(1'b0, 12'h818, 32'h1234_5678, 3, 32'hDEAD_BEEF, 1'b0, 1);
    n_vec++; if (o_psel !== e_psel || o_acc !== e_acc || o_lat !== e_lat) begin n_err++; $display("FAIL rd_timing: psel=%b acc=%0d lat=%0d want %b/%0d/%0d", o_psel, o_acc, o_lat, e_psel, e_acc, e_lat); end
    n_vec++; if (o_paddr !== 10'h018 || o_pwrite !== 1'b0 || o_unstable) begin n_err++; $display("FAIL rd_bus: paddr=%h pwrite=%b unstable=%b want 018/0/0", o_paddr, o_pwrite, o_unstable); end
    n_vec++; if (o_rdata !== e_rdata || o_err !== e_err) begin n_err++; $display("FAIL rd_rsp: rdata=%h err=%b want %h/%b", o_rdata, o_err, e_rdata, e_err); end
  endtask

  task automatic test_decode_error;
    model(1'b0, 12'hC04, 32'hFFFF_FFFF, 1'b0, 0);
    run_txn(1'b0, 12'hC04, 32'h0, 0, 32'hFFFF_FFFF, 1'b0, 0);
    n_vec++; if (o_lat !== e_lat || o_psel !== '0 || o_acc !== 0) begin n_err++; $display("FAIL dec_timing: lat=%0d psel=%b acc=%0d want %0d/0/0", o_lat, o_psel, o_acc, e_lat); end
    n_vec++; if (o_err !== 1'b1 || o_rdata !== 32'd0) begin n_err++; $display("FAIL dec_rsp: err=%b rdata=%h want 1/0", o_err, o_rdata); end
    n_vec++; if (o_after_valid !== 1'b0 || o_after_ready !== 1'b1) begin n_err++; $display("FAIL dec_done: valid=%b ready=%b want 0/1", o_after_valid, o_after_ready); end
  endtask

  task automatic test_slverr_hold;
    model(1'b1, 12'h47C, 32'h0, 1'b1, 1);
    run_txn(1'b1, 12'h47C, 32'hA5A5_0F0F, 1, 32'hCAFE_0000, 1'b1, 5);
    n_vec++; if (o_err !== e_err || o_rdata !== e_rdata) begin n_err++; $display("FAIL slverr_rsp: err=%b rdata=%h want %b/%h", o_err, o_rdata, e_err, e_rdata); end
    n_vec++; if (o_hold_bad || o_busy_ready) begin n_err++; $display("FAIL slverr_hold: hold_bad=%b busy_ready=%b want 0/0", o_hold_bad, o_busy_ready); end
    n_vec++; if (o_after_valid !== 1'b0 || o_after_ready !== 1'b1) begin n_err++; $display("FAIL slverr_done: valid=%b ready=%b want 0/1", o_after_valid, o_after_ready); end
  endtask

  task automatic test_stall;
    model(1'b0, 12'h010, 32'h7777_1111, 1'b0, 40);
    run_txn(1'b0, 12'h010, 32'h0, 40, 32'h7777_1111, 1'b0, 0);
    n_vec++; if (o_acc !== e_acc || o_lat !== e_lat) begin n_err++; $display("FAIL stall_timing: acc=%0d lat=%0d want %0d/%0d", o_acc, o_lat, e_acc, e_lat); end
    n_vec++; if (o_err !== e_err || o_rdata !== e_rdata || o_hold_bad) begin n_err++; $display("FAIL stall_rsp: err=%b rdata=%h hold_bad=%b want %b/%h/0", o_err, o_rdata, o_hold_bad, e_err, e_rdata); end
  endtask

  task automatic test_reset_midxfer;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 12'h404; bus.m_PREADY = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    n_vec++; if (bus.m_PSEL !== 3'b010 || bus.m_PENABLE !== 1'b1) begin n_err++; $display("FAIL mid_pre: psel=%b pen=%b want 010/1", bus.m_PSEL, bus.m_PENABLE); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (bus.m_PSEL !== '0 || bus.m_PENABLE !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_async: psel=%b pen=%b rv=%b want 0/0/0", bus.m_PSEL, bus.m_PENABLE, bus.rsp_valid); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_vec++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_release: ready=%b rv=%b want 1/0", bus.cmd_ready, bus.rsp_valid); end
    model(1'b0, 12'h420, 32'h0BAD_F00D, 1'b0, 2);
    run_txn(1'b0, 12'h420, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 0);
    n_vec++; if (o_lat !== e_lat || o_psel !== e_psel || o_rdata !== e_rdata || o_err !== e_err) begin n_err++; $display("FAIL mid_next: lat=%0d psel=%b rdata=%h err=%b want %0d/%b/%h/%b", o_lat, o_psel, o_rdata, o_err, e_lat, e_psel, e_rdata, e_err); end
  endtask

  task automatic test_random;
    logic             wr, se;
    logic [ADDR_W-1:0] ad;
    logic [31:0]      wd, rd;
    int               wt, dl;
    for (int k = 0; k < 24; k++) begin
      wr = 1'($urandom); ad = ADDR_W'($urandom); wd = $urandom; rd = $urandom;
      se = ($urandom_range(0, 3) == 0); wt = $urandom_range(0, 4); dl = $urandom_range(0, 3);
      model(wr, ad, rd, se, wt);
      run_txn(wr, ad, wd, wt, rd, se, dl);
      n_vec++; if (o_lat !== e_lat || o_acc !== e_acc || o_psel !== e_psel) begin n_err++; $display("FAIL rnd%0d_timing: lat=%0d acc=%0d psel=%b want %0d/%0d/%b", k, o_lat, o_acc, o_psel, e_lat, e_acc, e_psel); end
      n_vec++; if (o_rdata !== e_rdata || o_err !== e_err) begin n_err++; $display("FAIL rnd%0d_rsp: rdata=%h err=%b want %h/%b", k, o_rdata, o_err, e_rdata, e_err); end
      if (e_psel != '0) begin
        n_vec++; if (o_paddr !== e_paddr || o_pwrite !== wr || o_pwdata !== wd || o_unstable) begin n_err++; $display("FAIL rnd%0d_bus: paddr=%h pw=%b wd=%h unst=%b want %h/%b/%h/0", k, o_paddr, o_pwrite, o_pwdata, o_unstable, e_paddr, wr, wd); end
      end
      n_vec++; if (!o_idle_ready || o_busy_ready || o_hold_bad || o_after_valid || !o_after_ready) begin n_err++; $display("FAIL rnd%0d_hs: idle=%b busy=%b hold=%b av=%b ar=%b want 1/0/0/0/1", k, o_idle_ready, o_busy_ready, o_hold_bad, o_after_valid, o_after_ready); end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0; bus.m_PREADY = 1'b0; bus.m_PRDATA = '0; bus.m_PSLVERROR = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    test_write();
    test_read_wait();
    test_decode_error();
    test_slverr_hold();
    test_stall();
    test_reset_midxfer();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
